delay_pipe: RTL

// - Parametrised, stallable data delay line: WIDTH-bit samples with a valid
//   bit, delayed by a run-time selectable 1..DEPTH clock edges.
// - Successor to the fixed two-flop delay: adds width/depth parameters, valid

---
 rtl/delay_pipe_pkg.sv | 25 ++
 rtl/delay_pipe_stage.sv | 39 +++
 rtl/delay_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/delay_pipe_pkg.sv
// Shared helpers for the stallable delay line: width calculation and the
// clamp that maps a requested delay onto the legal range 1..DEPTH.
package delay_pipe_pkg;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // A request of 0 still means "at least one register"; anything past the
  // last stage saturates at the maximum delay.
  function automatic int clamp_dly(input int sel, input int depth);
    if (sel < 1)     return 1;
    if (sel > depth) return depth;
    return sel;
  endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One {vld, data} register of the delay line, with hold, load and a
// valid-only clear.
module delay_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t q;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the chain shifts by one.
  // NOTE: data is reset as well as vld so the output tap reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q.vld <= 1'b0;
    end else if (en) begin
      q <= '{vld: in_vld, data: in_data};
    end
  end

  assign vld  = q.vld;
  assign data = q.data;

endmodule

// File: rtl/delay_pipe.sv
// Stallable delay line with a run-time selectable tap (1..DEPTH), flush and
// a registered count of valid samples ahead of the tap.
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DLY_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [DLY_W-1:0] dly_sel,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic [DLY_W-1:0] cnt
);

  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] dly_eff;
  logic [DLY_W-1:0] cnt_next;
  logic             clr;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] sh_vld;
  logic [DEPTH-1:0] vld_next;
  logic [WIDTH-1:0] data    [DEPTH];
  logic [WIDTH-1:0] sh_data [DEPTH];

  assign dly_eff = DLY_W'(clamp_dly(32'(dly_sel), DEPTH));

  // Changing the tap would splice samples of different ages together, so a
  // delay change empties the pipe just like a flush.
  assign clr = flush || (dly_eff != dly_q);

  assign sh_vld = {vld[DEPTH-2:0], in_vld};

  always_comb begin
    sh_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) sh_data[i] = data[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    delay_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (clr),
      .in_vld  (sh_vld[i]),
      .in_data (sh_data[i]),
      .vld     (vld[i]),
      .data    (data[i])
    );
  end

  assign vld_next = clr ? '0 : (en ? sh_vld : vld);

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((DLY_W'(i) < dly_eff) && vld_next[i]) cnt_next = cnt_next + 1'b1;
    end
  end

  always_comb begin
    out_vld  = 1'b0;
    out_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dly_q == DLY_W'(i + 1)) begin
        out_vld  = vld[i];
        out_data = data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= DLY_W'(DEPTH);
      cnt   <= '0;
    end else begin
      dly_q <= dly_eff;
      cnt   <= cnt_next;
    end
  end

endmodule
